id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU.
- Decodes opcode/funct into the 4-bit ALU select, sign- or zero-extends immediates, and forwards operands from EX/MEM and MEM/WB.
- Registers a, b, sel and shamt plus control bits for the EX stage.
- One-cycle latency, with stall (hold) and flush (bubble) control.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold all EX registers.
- flush  in  1  insert bubble; priority over stall.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  6  instr[31:26].
- id_funct  in  6  instr[5:0].
- id_shamt  in  5  instr[10:6].
- id_imm  in  16  instr[15:0].
- id_rs, id_rt, id_rd  in  RW each  register addresses.
- id_rs_data, id_rt_data  in  DW each  register-file read data.
- exmem_regwrite  in  1  EX/MEM writes a register.
- exmem_rd  in  RW  EX/MEM destination.
- exmem_result  in  DW  EX/MEM result.
- memwb_regwrite  in  1  MEM/WB writes a register.
- memwb_rd  in  RW  MEM/WB destination.
- memwb_result  in  DW  MEM/WB result.
- ex_valid  out  1  EX slot valid.
- ex_a, ex_b  out  DW each  ALU operands.
- ex_sel  out  4  ALU select.
- ex_shamt  out  5  ALU shift amount.
- ex_store_data  out  DW  forwarded rt, for sw.
- ex_dest  out  RW  write-back register.
- ex_rt  out  RW  rt address, for the load-use hazard unit.
- ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne, ex_illegal  out  1 each  control bits.

Behaviour:
- Reset: every output is 0, asynchronously. Reset mid-stall or mid-flush also forces all outputs to 0.
- Latency: ID inputs sampled on edge N appear on the outputs after edge N.
- Edge priority: reset > flush > stall > load.
  - Flush: ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne and ex_illegal go to 0; data registers hold.
  - Stall: all registers hold.
  - Load with id_valid=0: same result as flush.
- Forwarding, per source rs and rt: EX/MEM wins if exmem_regwrite && exmem_rd==src && src!=0; else MEM/WB under the same test; else register-file data. Register 0 is never forwarded.
- R-type (opcode 0x00), funct → sel:
  - 20/21→2, 22/23→6, 24→0, 25→1, 26→8, 27→4, 2A→7
  - 00→3, 02→5, 03→9 (shifts)
  - 04→12, 06→11, 07→10 (variable shifts)
  - Operands: a=rs, b=rt, dest=rd, regwrite=1, shamt=id_shamt.
  - Variable shifts (sel 10/11/12): ex_a = {27'b0, rs[4:0]}.
- I-type, opcode → sel:
  - 08/09→2 with sign-extended imm.
  - 0A→7 with sign-extended imm.
  - 0C→0, 0D→1, 0E→8 with zero-extended imm.
  - 0F (lui): a=0, b={imm,16'b0}, sel=2.
  - 23 (lw): sel=2, sign-extended imm, memread=1.
  - 2B (sw): sel=2, sign-extended imm, memwrite=1, regwrite=0.
  - 04/05 (beq/bne): sel=6, b=rt, branch=1, regwrite=0; branch_ne=1 for 05.
  - Non-R I-type ops: dest=rt, shamt=0.
- regwrite is forced to 0 whenever dest==0.
- Illegal opcode or funct: ex_illegal=1, ex_valid=1, sel=4'b1111, regwrite/memread/memwrite/branch all 0.
- Simultaneous stall+flush: flush wins.

Optional Feature:
- Macro ID_EX_FWD_EN.
- Defined: forwarding muxes active as described.
- Undefined: the forwarding ports remain but are ignored; operands always come from the register file. Hazards are then resolved by stalls elsewhere.

Decomposition:
- Package id_ex_pkg: opcode and funct localparams, the 4-bit ALU sel encodings (AND=0 … SLLV=12, ILLEGAL=15), and immediate-extension mode constants.
- Sub-module alu_decoder: combinational opcode/funct → sel, imm mode, control bits, illegal.

Test Plan:
- add r3,r1,r2 with r1=5, r2=7, no hazards → next edge: ex_sel=2, ex_a=5, ex_b=7, ex_dest=3, ex_regwrite=1.
- addi with imm=0xFFFF, then andi with imm=0xFFFF → ex_b=0xFFFFFFFF (sel 2), then ex_b=0x0000FFFF (sel 0).
- rs=4 matching both exmem_rd=4 (result 0xAA) and memwb_rd=4 (result 0xBB) → ex_a=0xAA. Repeat with rs=0 → ex_a=id_rs_data.
- srav with rs=0x00000123 → ex_sel=10, ex_a=3. sll with shamt=31 → ex_sel=3, ex_shamt=31.
- Load add, assert stall for 2 cycles → outputs hold. Assert stall+flush → ex_valid=0, ex_regwrite=0.
- opcode 0x3F → ex_illegal=1, ex_sel=15. Assert reset mid-stream → all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared decode constants for the ID/EX stage: opcodes, functs, ALU select codes,
// immediate-extension modes and the decoded control bundle.
package id_ex_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [3:0] SEL_AND     = 4'd0;
  localparam logic [3:0] SEL_OR      = 4'd1;
  localparam logic [3:0] SEL_ADD     = 4'd2;
  localparam logic [3:0] SEL_SLL     = 4'd3;
  localparam logic [3:0] SEL_NOR     = 4'd4;
  localparam logic [3:0] SEL_SRL     = 4'd5;
  localparam logic [3:0] SEL_SUB     = 4'd6;
  localparam logic [3:0] SEL_SLT     = 4'd7;
  localparam logic [3:0] SEL_XOR     = 4'd8;
  localparam logic [3:0] SEL_SRA     = 4'd9;
  localparam logic [3:0] SEL_SRAV    = 4'd10;
  localparam logic [3:0] SEL_SRLV    = 4'd11;
  localparam logic [3:0] SEL_SLLV    = 4'd12;
  localparam logic [3:0] SEL_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SEXT = 2'd1,
    IMM_ZEXT = 2'd2,
    IMM_LUI  = 2'd3
  } imm_mode_e;

  typedef struct packed {
    logic [3:0] sel;
    imm_mode_e  imm_mode;
    logic       rtype;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       branch_ne;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_var_shift(input logic [3:0] sel);
    return (sel == SEL_SRAV) || (sel == SEL_SRLV) || (sel == SEL_SLLV);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode into ALU select, immediate mode and control bits.
module alu_decoder
  import id_ex_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl          = '0;
    ctrl.imm_mode = IMM_NONE;
    ctrl.sel      = SEL_ADD;
    ctrl.regwrite = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl.rtype = 1'b1;
        case (funct)
          F_ADD, F_ADDU: ctrl.sel = SEL_ADD;
          F_SUB, F_SUBU: ctrl.sel = SEL_SUB;
          F_AND:         ctrl.sel = SEL_AND;
          F_OR:          ctrl.sel = SEL_OR;
          F_XOR:         ctrl.sel = SEL_XOR;
          F_NOR:         ctrl.sel = SEL_NOR;
          F_SLT:         ctrl.sel = SEL_SLT;
          F_SLL:         ctrl.sel = SEL_SLL;
          F_SRL:         ctrl.sel = SEL_SRL;
          F_SRA:         ctrl.sel = SEL_SRA;
          F_SLLV:        ctrl.sel = SEL_SLLV;
          F_SRLV:        ctrl.sel = SEL_SRLV;
          F_SRAV:        ctrl.sel = SEL_SRAV;
          default:       ctrl.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: ctrl.imm_mode = IMM_SEXT;
      OP_SLTI: begin
        ctrl.sel      = SEL_SLT;
        ctrl.imm_mode = IMM_SEXT;
      end
      OP_ANDI: begin
        ctrl.sel      = SEL_AND;
        ctrl.imm_mode = IMM_ZEXT;
      end
      OP_ORI: begin
        ctrl.sel      = SEL_OR;
        ctrl.imm_mode = IMM_ZEXT;
      end
      OP_XORI: begin
        ctrl.sel      = SEL_XOR;
        ctrl.imm_mode = IMM_ZEXT;
      end
      OP_LUI: ctrl.imm_mode = IMM_LUI;
      OP_LW: begin
        ctrl.imm_mode = IMM_SEXT;
        ctrl.memread  = 1'b1;
      end
      OP_SW: begin
        ctrl.imm_mode = IMM_SEXT;
        ctrl.memwrite = 1'b1;
        ctrl.regwrite = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.sel       = SEL_SUB;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = (opcode == OP_BNE);
        ctrl.regwrite  = 1'b0;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Illegal ops still occupy a valid slot, but must not touch state.
    if (ctrl.illegal) begin
      ctrl.sel       = SEL_ILLEGAL;
      ctrl.imm_mode  = IMM_NONE;
      ctrl.regwrite  = 1'b0;
      ctrl.memread   = 1'b0;
      ctrl.memwrite  = 1'b0;
      ctrl.branch    = 1'b0;
      ctrl.branch_ne = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, immediate extension and operand forwarding.
// Forwarding from EX/MEM and MEM/WB is compiled in only when ID_EX_FWD_EN is defined.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [4:0]    id_shamt,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_sel,
  output logic [4:0]    ex_shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic [RW-1:0] ex_rt,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_branch,
  output logic          ex_branch_ne,
  output logic          ex_illegal
);

  ctrl_t         ctrl;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [DW-1:0] a_nxt;
  logic [DW-1:0] b_nxt;
  logic [RW-1:0] dest_nxt;
  logic [4:0]    shamt_nxt;
  logic          regwrite_nxt;

  alu_decoder u_dec (
    .opcode (id_opcode),
    .funct  (id_funct),
    .ctrl   (ctrl)
  );

`ifdef ID_EX_FWD_EN
  // The younger producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
  always_comb begin
    rs_val = id_rs_data;
    if (exmem_regwrite && exmem_rd == id_rs && id_rs != '0)      rs_val = exmem_result;
    else if (memwb_regwrite && memwb_rd == id_rs && id_rs != '0) rs_val = memwb_result;
    rt_val = id_rt_data;
    if (exmem_regwrite && exmem_rd == id_rt && id_rt != '0)      rt_val = exmem_result;
    else if (memwb_regwrite && memwb_rd == id_rt && id_rt != '0) rt_val = memwb_result;
  end
`else
  assign rs_val = id_rs_data;
  assign rt_val = id_rt_data;
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                        memwb_regwrite, memwb_rd, memwb_result};
`endif

  always_comb begin
    a_nxt = rs_val;
    b_nxt = rt_val;
    case (ctrl.imm_mode)
      IMM_SEXT: b_nxt = {{(DW-16){id_imm[15]}}, id_imm};
      IMM_ZEXT: b_nxt = {{(DW-16){1'b0}}, id_imm};
      IMM_LUI: begin
        a_nxt        = '0;
        b_nxt        = '0;
        b_nxt[31:16] = id_imm;
      end
      default: ;
    endcase
    // Variable shifts carry the shift count in rs; only its low 5 bits matter.
    if (is_var_shift(ctrl.sel)) begin
      a_nxt      = '0;
      a_nxt[4:0] = rs_val[4:0];
    end
  end

  assign dest_nxt     = ctrl.rtype ? id_rd : id_rt;
  assign shamt_nxt    = ctrl.rtype ? id_shamt : 5'd0;
  assign regwrite_nxt = ctrl.regwrite && (dest_nxt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_sel        <= '0;
      ex_shamt      <= '0;
      ex_store_data <= '0;
      ex_dest       <= '0;
      ex_rt         <= '0;
      ex_regwrite   <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_branch     <= 1'b0;
      ex_branch_ne  <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      // Bubble: kill control only, data registers keep their last value.
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_branch    <= 1'b0;
      ex_branch_ne <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= 1'b1;
      ex_a          <= a_nxt;
      ex_b          <= b_nxt;
      ex_sel        <= ctrl.sel;
      ex_shamt      <= shamt_nxt;
      ex_store_data <= rt_val;
      ex_dest       <= dest_nxt;
      ex_rt         <= id_rt;
      ex_regwrite   <= regwrite_nxt;
      ex_memread    <= ctrl.memread;
      ex_memwrite   <= ctrl.memwrite;
      ex_branch     <= ctrl.branch;
      ex_branch_ne  <= ctrl.branch_ne;
      ex_illegal    <= ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random stimulus for id_ex_stage with a queue-based scoreboard and
// an independent reference decode model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int OW = 122;
`ifdef ID_EX_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam int NOPS = 26;
  localparam logic [5:0] OPC [0:NOPS-1] = '{
    6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
    6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
  localparam logic [5:0] FNC [0:NOPS-1] = '{
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04,
    6'h06, 6'h07, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [5:0]    id_opcode = '0;
  logic [5:0]    id_funct = '0;
  logic [4:0]    id_shamt = '0;
  logic [15:0]   id_imm = '0;
  logic [RW-1:0] id_rs = '0;
  logic [RW-1:0] id_rt = '0;
  logic [RW-1:0] id_rd = '0;
  logic [DW-1:0] id_rs_data = '0;
  logic [DW-1:0] id_rt_data = '0;
  logic          exmem_regwrite = 1'b0;
  logic [RW-1:0] exmem_rd = '0;
  logic [DW-1:0] exmem_result = '0;
  logic          memwb_regwrite = 1'b0;
  logic [RW-1:0] memwb_rd = '0;
  logic [DW-1:0] memwb_result = '0;
  logic          ex_valid;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [3:0]    ex_sel;
  logic [4:0]    ex_shamt;
  logic [DW-1:0] ex_store_data;
  logic [RW-1:0] ex_dest;
  logic [RW-1:0] ex_rt;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_branch;
  logic          ex_branch_ne;
  logic          ex_illegal;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] cur = '0;
  int            checks = 0;
  int            failures = 0;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct(id_funct), .id_shamt(id_shamt), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_sel(ex_sel), .ex_shamt(ex_shamt),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_rt(ex_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [OW-1:0] obs();
    return {ex_valid, ex_a, ex_b, ex_sel, ex_shamt, ex_store_data, ex_dest, ex_rt,
            ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_branch_ne, ex_illegal};
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] rf);
    if (FWD_EN && src != 0 && exmem_regwrite && exmem_rd == src) return exmem_result;
    if (FWD_EN && src != 0 && memwb_regwrite && memwb_rd == src) return memwb_result;
    return rf;
  endfunction

  // Reference decode of the current ID inputs into the full expected output vector.
  function automatic logic [OW-1:0] model();
    logic [DW-1:0] ra, rb, a, b, sx, zx;
    logic [3:0]    sel;
    logic [4:0]    sh;
    logic [RW-1:0] dest;
    logic          rw, mr, mw, br, bne, ill;
    ra = fwd(id_rs, id_rs_data);
    rb = fwd(id_rt, id_rt_data);
    sx = {{16{id_imm[15]}}, id_imm};
    zx = {16'h0000, id_imm};
    a = ra; b = rb; sel = 4'd0; sh = 5'd0; dest = id_rt;
    rw = 1'b1; mr = 1'b0; mw = 1'b0; br = 1'b0; bne = 1'b0; ill = 1'b0;
    if (id_opcode == 6'h00) begin
      dest = id_rd;
      sh   = id_shamt;
      case (id_funct)
        6'h20, 6'h21: sel = 4'd2;
        6'h22, 6'h23: sel = 4'd6;
        6'h24: sel = 4'd0;
        6'h25: sel = 4'd1;
        6'h26: sel = 4'd8;
        6'h27: sel = 4'd4;
        6'h2A: sel = 4'd7;
        6'h00: sel = 4'd3;
        6'h02: sel = 4'd5;
        6'h03: sel = 4'd9;
        6'h04: begin sel = 4'd12; a = {27'd0, ra[4:0]}; end
        6'h06: begin sel = 4'd11; a = {27'd0, ra[4:0]}; end
        6'h07: begin sel = 4'd10; a = {27'd0, ra[4:0]}; end
        default: ill = 1'b1;
      endcase
    end else begin
      case (id_opcode)
        6'h08, 6'h09: begin sel = 4'd2; b = sx; end
        6'h0A: begin sel = 4'd7; b = sx; end
        6'h0C: begin sel = 4'd0; b = zx; end
        6'h0D: begin sel = 4'd1; b = zx; end
        6'h0E: begin sel = 4'd8; b = zx; end
        6'h0F: begin sel = 4'd2; a = '0; b = {id_imm, 16'h0000}; end
        6'h23: begin sel = 4'd2; b = sx; mr = 1'b1; end
        6'h2B: begin sel = 4'd2; b = sx; mw = 1'b1; rw = 1'b0; end
        6'h04, 6'h05: begin sel = 4'd6; br = 1'b1; rw = 1'b0; bne = (id_opcode == 6'h05); end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      sel = 4'd15; rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; bne = 1'b0;
    end
    if (dest == 0) rw = 1'b0;
    return {1'b1, a, b, sel, sh, rb, dest, id_rt, rw, mr, mw, br, bne, ill};
  endfunction

  function automatic logic [OW-1:0] bubble_of(input logic [OW-1:0] v);
    logic [OW-1:0] r;
    r = v;
    r[OW-1] = 1'b0;
    r[5:0]  = 6'd0;
    return r;
  endfunction

  // Scoreboard
  task automatic check_vec(input string tag, input logic [OW-1:0] e);
    logic [OW-1:0] o;
    o = obs();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_field(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      checks--;
      check_vec(tag, exp_q.pop_front());
    end
  endtask

  // Drivers
  task automatic set_r(input logic [5:0] fn, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [RW-1:0] rd, input logic [4:0] sh,
                       input logic [DW-1:0] rsd, input logic [DW-1:0] rtd);
    id_valid = 1'b1; id_opcode = 6'h00; id_funct = fn; id_shamt = sh;
    id_imm = 16'($urandom_range(0, 65535));
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
  endtask

  task automatic set_i(input logic [5:0] op, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [15:0] imm, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd);
    id_valid = 1'b1; id_opcode = op; id_imm = imm;
    id_funct = 6'($urandom_range(0, 63)); id_shamt = 5'($urandom_range(0, 31));
    id_rd = RW'($urandom_range(0, 31));
    id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd;
  endtask

  task automatic set_fwd(input logic erw, input logic [RW-1:0] erd, input logic [DW-1:0] eres,
                         input logic mrw, input logic [RW-1:0] mrd, input logic [DW-1:0] mres);
    exmem_regwrite = erw; exmem_rd = erd; exmem_result = eres;
    memwb_regwrite = mrw; memwb_rd = mrd; memwb_result = mres;
  endtask

  task automatic do_load(input string tag);
    cur = id_valid ? model() : bubble_of(cur);
    exp_q.push_back(cur);
    tick(tag);
  endtask

  task automatic do_stall(input string tag);
    stall = 1'b1;
    exp_q.push_back(cur);
    tick(tag);
    stall = 1'b0;
  endtask

  task automatic do_flush(input string tag, input logic with_stall);
    flush = 1'b1;
    stall = with_stall;
    cur = bubble_of(cur);
    exp_q.push_back(cur);
    tick(tag);
    flush = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1 check_vec("reset_async", '0);
    repeat (2) @(posedge clk);
    #1 check_vec("reset_hold", '0);
    reset = 1'b0;
    cur = '0;
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    set_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd5, 32'd7);
    do_load("add");
    check_field("add_sel", 32'(ex_sel), 32'd2);
    check_field("add_a", ex_a, 32'd5);
    check_field("add_b", ex_b, 32'd7);
    check_field("add_dest", 32'(ex_dest), 32'd3);
    check_field("add_regwrite", 32'(ex_regwrite), 32'd1);

    set_i(6'h08, 5'd1, 5'd5, 16'hFFFF, 32'd9, 32'd11);
    do_load("addi_sext");
    check_field("addi_b", ex_b, 32'hFFFF_FFFF);
    set_i(6'h0C, 5'd1, 5'd5, 16'hFFFF, 32'd9, 32'd11);
    do_load("andi_zext");
    check_field("andi_b", ex_b, 32'h0000_FFFF);
    check_field("andi_sel", 32'(ex_sel), 32'd0);

    set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    set_r(6'h20, 5'd4, 5'd9, 5'd10, 5'd0, 32'h11, 32'h22);
    do_load("fwd_both");
    check_field("fwd_both_a", ex_a, FWD_EN ? 32'hAA : 32'h11);
    set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
    set_r(6'h20, 5'd0, 5'd9, 5'd10, 5'd0, 32'h33, 32'h22);
    do_load("fwd_r0");
    check_field("fwd_r0_a", ex_a, 32'h33);
    set_fwd(1'b0, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB);
    set_i(6'h2B, 5'd2, 5'd9, 16'h8004, 32'h1000, 32'h44);
    do_load("fwd_memwb_sw");
    check_field("sw_store", ex_store_data, FWD_EN ? 32'hBB : 32'h44);
    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

    set_r(6'h07, 5'd6, 5'd7, 5'd8, 5'd0, 32'h0000_0123, 32'h8000_0000);
    do_load("srav");
    check_field("srav_sel", 32'(ex_sel), 32'd10);
    check_field("srav_a", ex_a, 32'd3);
    set_r(6'h00, 5'd0, 5'd7, 5'd8, 5'd31, 32'h0, 32'h1);
    do_load("sll31");
    check_field("sll_shamt", 32'(ex_shamt), 32'd31);

    set_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd5, 32'd7);
    do_load("add_pre_stall");
    set_r(6'h22, 5'd12, 5'd13, 5'd14, 5'd7, 32'hDEAD, 32'hBEEF);
    do_stall("stall1");
    do_stall("stall2");
    do_flush("stall_flush", 1'b1);
    check_field("stall_flush_valid", 32'(ex_valid), 32'd0);
    check_field("stall_flush_regwrite", 32'(ex_regwrite), 32'd0);

    set_r(6'h25, 5'd1, 5'd2, 5'd3, 5'd0, 32'd1, 32'd2);
    do_load("or");
    id_valid = 1'b0;
    do_load("invalid_bubble");
    set_r(6'h20, 5'd1, 5'd2, 5'd0, 5'd0, 32'd1, 32'd2);
    do_load("rd_zero");
    set_i(6'h0F, 5'd3, 5'd4, 16'h1234, 32'h55, 32'h66);
    do_load("lui");
    set_i(6'h05, 5'd3, 5'd4, 16'h0010, 32'h55, 32'h66);
    do_load("bne");
    set_i(6'h3F, 5'd3, 5'd4, 16'h0010, 32'h55, 32'h66);
    do_load("illegal_op");
    check_field("illegal_flag", 32'(ex_illegal), 32'd1);
    check_field("illegal_sel", 32'(ex_sel), 32'd15);
    set_r(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 32'd1, 32'd2);
    do_load("illegal_funct");

    for (int i = 0; i < 40; i++) begin
      int k;
      int r;
      k = $urandom_range(0, NOPS - 1);
      set_fwd(1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)), $urandom);
      if (OPC[k] == 6'h00)
        set_r(FNC[k], RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
              RW'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom);
      else
        set_i(OPC[k], RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)),
              16'($urandom_range(0, 65535)), $urandom, $urandom);
      id_valid = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 7);
      if (r == 0) do_stall("rand_stall");
      else if (r == 1) do_flush("rand_flush", 1'($urandom_range(0, 1)));
      else do_load("rand_load");
    end

    set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    set_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'd5, 32'd7);
    do_load("add_pre_reset");
    do_stall("stall_pre_reset");
    stall = 1'b1;
    flush = 1'b1;
    #2 reset = 1'b1;
    #1 check_vec("reset_mid_async", '0);
    @(posedge clk);
    #1 check_vec("reset_mid_hold", '0);
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    cur = '0;
    set_r(6'h2A, 5'd1, 5'd2, 5'd3, 5'd0, 32'hFFFF_FFFE, 32'd7);
    do_load("slt_post_reset");

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
